// File: rtl/usb_speed_detect_pkg.sv
// Shared encodings for the USB speed autodetector: speed codes, FSM state codes, linestate values.
package usb_speed_detect_pkg;

  localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
  localparam logic [1:0] USB_SPEED_LS   = 2'd1;
  localparam logic [1:0] USB_SPEED_FS   = 2'd2;
  localparam logic [1:0] USB_SPEED_HS   = 2'd3;

  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;

  // Values are visible on O_state, so register/ILA decoders depend on them staying fixed.
  typedef enum logic [3:0] {
    USB_AD_S_IDLE     = 4'd0,
    USB_AD_S_LS       = 4'd1,
    USB_AD_S_FSHS     = 4'd2,
    USB_AD_S_WAIT_SE0 = 4'd3,
    USB_AD_S_SE0      = 4'd4,
    USB_AD_S_CHIRP_K  = 4'd5,
    USB_AD_S_CHIRP_KJ = 4'd6,
    USB_AD_S_DONE     = 4'd7,
    USB_AD_S_ERROR    = 4'd8
  } ad_state_e;

endpackage

// File: rtl/usb_speed_detect_filter.sv
// Linestate glitch filter: output follows the raw linestate only after pFILT_LEN identical samples.
// Latency pFILT_LEN cycles from a raw change; shorter pulses never reach the output.
module usb_linestate_filter #(
  parameter int pFILT_LEN = 4
) (
  input  logic       fe_clk,
  input  logic       reset_n,
  input  logic [1:0] raw_i,
  output logic [1:0] filt_o
);

  localparam int CW = $clog2(pFILT_LEN + 1);

  logic [1:0]    cand_q;
  logic [1:0]    filt_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_d is the run length of identical samples including the current one, capped at pFILT_LEN.
  always_comb begin
    cnt_d = cnt_q;
    if (raw_i != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CW'(pFILT_LEN)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= 2'b00;
      cnt_q  <= '0;
      filt_q <= 2'b00;
    end else begin
      cand_q <= raw_i;
      cnt_q  <= cnt_d;
      if (cnt_d == CW'(pFILT_LEN)) begin
        filt_q <= raw_i;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/usb_speed_detect.sv
// USB attach speed classifier (LS/FS/HS) from filtered UTMI linestate, legacy or chirp HS rule.
// Optional saturating ERROR-entry counter on O_err_count when USB_AUTODETECT_STATS_EN is defined.
module usb_speed_detect
  import usb_speed_detect_pkg::*;
#(
  parameter int pCOUNTER_WIDTH = 24,
  parameter int pFILT_LEN      = 4,
  parameter int pKJ_WIDTH      = 4
) (
  input  logic                      fe_clk,
  input  logic                      reset_n,
  input  logic                      fe_linestate0,
  input  logic                      fe_linestate1,
  input  logic                      I_restart,
  input  logic                      I_chirp_mode,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
  input  logic [pCOUNTER_WIDTH-1:0] I_chirp_min,
  input  logic [pKJ_WIDTH-1:0]      I_kj_min,
  output logic [1:0]                O_speed,
  output logic                      O_done,
  output logic [3:0]                O_state,
  output logic [7:0]                O_err_count
);

  logic [1:0]                filt;
  logic [1:0]                filt_prev_q;
  ad_state_e                 state_q, state_d;
  logic [pCOUNTER_WIDTH-1:0] timer_q, timer_d;
  logic [pKJ_WIDTH-1:0]      kj_q, kj_d;
  logic [1:0]                tgt_q, tgt_d;
  logic [1:0]                speed_q, speed_d;
  logic                      done_q, done_d;
  logic                      filt_edge;
  logic                      kj_pair;

  usb_linestate_filter #(
    .pFILT_LEN (pFILT_LEN)
  ) u_filt (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .raw_i   ({fe_linestate1, fe_linestate0}),
    .filt_o  (filt)
  );

  assign filt_edge = (filt != filt_prev_q);
  assign kj_pair   = (filt_prev_q == LINE_K) && (filt == LINE_J);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      USB_AD_S_IDLE: begin
        if (filt == LINE_K) begin
          state_d = USB_AD_S_LS;
        end else if (filt == LINE_J) begin
          state_d = USB_AD_S_FSHS;
        end
      end
      USB_AD_S_LS: begin
        if (filt != LINE_K) begin
          state_d = USB_AD_S_ERROR;
        end else if (timer_q >= I_wait1) begin
          state_d = USB_AD_S_DONE;
          tgt_d   = USB_SPEED_LS;
        end
      end
      USB_AD_S_FSHS: begin
        if (filt != LINE_J) begin
          state_d = USB_AD_S_ERROR;
        end else if (timer_q >= I_wait1) begin
          state_d = USB_AD_S_WAIT_SE0;
        end
      end
      USB_AD_S_WAIT_SE0: begin
        if (filt == LINE_SE0) begin
          state_d = USB_AD_S_SE0;
        end else if (filt == LINE_K) begin
          state_d = USB_AD_S_ERROR;
        end
      end
      USB_AD_S_SE0: begin
        if (!I_chirp_mode) begin
          if (timer_q >= I_wait2) begin
            state_d = USB_AD_S_DONE;
            tgt_d   = USB_SPEED_HS;
          end else if (filt == LINE_J) begin
            state_d = USB_AD_S_DONE;
            tgt_d   = USB_SPEED_FS;
          end else if (filt == LINE_K) begin
            state_d = USB_AD_S_ERROR;
          end
        end else begin
          if (filt == LINE_K) begin
            state_d = USB_AD_S_CHIRP_K;
          end else if (filt == LINE_J || timer_q >= I_wait2) begin
            state_d = USB_AD_S_DONE;
            tgt_d   = USB_SPEED_FS;
          end
        end
      end
      USB_AD_S_CHIRP_K: begin
        if (filt == LINE_SE0) begin
          state_d = (timer_q >= I_chirp_min) ? USB_AD_S_CHIRP_KJ : USB_AD_S_ERROR;
        end else if (filt == LINE_J) begin
          state_d = USB_AD_S_ERROR;
        end
      end
      USB_AD_S_CHIRP_KJ: begin
        if (kj_q >= I_kj_min) begin
          state_d = USB_AD_S_DONE;
          tgt_d   = USB_SPEED_HS;
        end else if (filt == LINE_SE0 && timer_q >= I_wait2) begin
          state_d = USB_AD_S_DONE;
          tgt_d   = USB_SPEED_FS;
        end
      end
      USB_AD_S_DONE:  state_d = USB_AD_S_DONE;
      USB_AD_S_ERROR: state_d = USB_AD_S_IDLE;
      default:        state_d = USB_AD_S_IDLE;
    endcase
    if (I_restart) begin
      state_d = USB_AD_S_IDLE;
    end
  end

  // Timer measures time in the current state; during host chirps it measures time since the last edge.
  always_comb begin
    timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    if (state_d != state_q || state_q == USB_AD_S_IDLE || state_q == USB_AD_S_WAIT_SE0 ||
        (state_q == USB_AD_S_CHIRP_KJ && filt_edge)) begin
      timer_d = '0;
    end

    kj_d = kj_q;
    if (state_d != USB_AD_S_CHIRP_KJ) begin
      kj_d = '0;
    end else if (state_q == USB_AD_S_CHIRP_KJ && kj_pair && kj_q != '1) begin
      kj_d = kj_q + 1'b1;
    end

    speed_d = speed_q;
    if (state_d == USB_AD_S_IDLE || state_d == USB_AD_S_ERROR) begin
      speed_d = USB_SPEED_AUTO;
    end else if (state_q == USB_AD_S_DONE) begin
      speed_d = tgt_q;
    end

    done_d = (state_d == USB_AD_S_DONE) && (state_q != USB_AD_S_DONE);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= USB_AD_S_IDLE;
      filt_prev_q <= 2'b00;
      timer_q     <= '0;
      kj_q        <= '0;
      tgt_q       <= USB_SPEED_AUTO;
      speed_q     <= USB_SPEED_AUTO;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_prev_q <= filt;
      timer_q     <= timer_d;
      kj_q        <= kj_d;
      tgt_q       <= tgt_d;
      speed_q     <= speed_d;
      done_q      <= done_d;
    end
  end

`ifdef USB_AUTODETECT_STATS_EN
  logic [7:0] err_q;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 8'd0;
    end else if (state_d == USB_AD_S_ERROR && state_q != USB_AD_S_ERROR && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign O_err_count = err_q;
`else
  assign O_err_count = 8'd0;
`endif

  assign O_speed = speed_q;
  assign O_done  = done_q;
  assign O_state = state_q;

endmodule
